// File: rtl/aes_stream_slave.sv
// Avalon-MM slave front end for a 128-bit AES block engine: word packing, input/output block
// FIFOs, start/done dispatch and CBC chaining. Optional irq output under `define AES_IRQ_EN.
module aes_stream_slave #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IN_DEPTH  = 2,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              chipselect,
  input  logic [3:0]        address,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic              waitrequest,
  output logic              core_start,
  output logic [127:0]      core_text,
  output logic [127:0]      core_key,
  input  logic              core_done,
  input  logic [127:0]      core_result
`ifdef AES_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned W       = 128 / DATA_W;
  localparam int unsigned InPtrW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned OutPtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [2:0]         LastWord = 3'(W - 1);
  localparam logic [3:0]         InDepth  = 4'(IN_DEPTH);
  localparam logic [3:0]         OutDepth = 4'(OUT_DEPTH);
  localparam logic [InPtrW-1:0]  InLast   = InPtrW'(IN_DEPTH - 1);
  localparam logic [OutPtrW-1:0] OutLast  = OutPtrW'(OUT_DEPTH - 1);

  localparam logic [3:0] AddrDataIn  = 4'h0;
  localparam logic [3:0] AddrDataOut = 4'h4;
  localparam logic [3:0] AddrStatus  = 4'h8;
  localparam logic [3:0] AddrCtrl    = 4'hC;
  localparam logic [3:0] AddrKey     = 4'h1;
  localparam logic [3:0] AddrIv      = 4'h2;

  typedef enum logic [1:0] {StIdle, StStart, StWait, StWb} state_e;

  state_e              state_q, state_d;
  logic [127:0]        din_q, din_d, key_q, key_d, iv_q, iv_d, chain_q, chain_d;
  logic [127:0]        text_q, text_d, result_q, result_d;
  logic [2:0]          pack_cnt_q, pack_cnt_d, unpack_cnt_q, unpack_cnt_d;
  logic [2:0]          key_cnt_q, key_cnt_d, iv_cnt_q, iv_cnt_d;
  logic                cbc_en_q, cbc_en_d;
  logic [InPtrW-1:0]   in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [OutPtrW-1:0]  out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [3:0]          in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [127:0]        in_mem  [1 << InPtrW];
  logic [127:0]        out_mem [1 << OutPtrW];

  logic         wr_cyc, rd_cyc, idle, in_full, out_avail, flush;
  logic         din_acc, dout_acc, key_acc, iv_acc, ctrl_acc;
  logic         in_push, in_pop, out_push, out_pop;
  logic [127:0] din_shift, key_shift, iv_shift, in_head, out_head;
  logic [11:0]  status;

  assign wr_cyc    = chipselect & write;
  assign rd_cyc    = chipselect & read;
  assign idle      = (state_q == StIdle);
  assign in_full   = (in_cnt_q == InDepth);
  assign out_avail = (out_cnt_q != 4'd0);
  assign in_head   = in_mem[in_rd_q];
  assign out_head  = out_mem[out_rd_q];
  assign status    = {out_cnt_q, in_cnt_q, cbc_en_q, ~idle, in_full, out_avail};

  // New words enter at the LSB end so the first word of a block ends up in the MSBs.
  assign din_shift = (din_q << DATA_W) | 128'(writedata);
  assign key_shift = (key_q << DATA_W) | 128'(writedata);
  assign iv_shift  = (iv_q << DATA_W) | 128'(writedata);

  always_comb begin
    waitrequest = 1'b0;
    if (wr_cyc) begin
      case (address)
        AddrDataIn:                 waitrequest = (pack_cnt_q == LastWord) && in_full;
        AddrKey, AddrIv, AddrCtrl:  waitrequest = ~idle;
        default:                    waitrequest = 1'b0;
      endcase
    end else if (rd_cyc && address == AddrDataOut) begin
      waitrequest = ~out_avail;
    end
  end

  always_comb begin
    readdata = '0;
    if (rd_cyc) begin
      case (address)
        AddrDataOut: if (out_avail) readdata = out_head[127 - DATA_W * int'(unpack_cnt_q) -: DATA_W];
        AddrStatus:  readdata = {{(DATA_W - 12){1'b0}}, status};
        default:     readdata = '0;
      endcase
    end
  end

  assign din_acc  = wr_cyc & ~waitrequest & (address == AddrDataIn);
  assign key_acc  = wr_cyc & ~waitrequest & (address == AddrKey);
  assign iv_acc   = wr_cyc & ~waitrequest & (address == AddrIv);
  assign ctrl_acc = wr_cyc & ~waitrequest & (address == AddrCtrl);
  assign dout_acc = rd_cyc & ~waitrequest & (address == AddrDataOut);
  assign flush    = ctrl_acc & writedata[1];

  assign in_push  = din_acc & (pack_cnt_q == LastWord);
  assign in_pop   = (state_q == StStart);
  assign out_push = (state_q == StWb);
  assign out_pop  = dout_acc & (unpack_cnt_q == LastWord);

  assign core_start = (state_q == StStart);
  assign core_text  = text_q;
  assign core_key   = key_q;

  // Pack/unpack counters, key/IV registers and both FIFO pointer sets.
  always_comb begin
    din_d        = din_q;
    key_d        = key_q;
    iv_d         = iv_q;
    pack_cnt_d   = pack_cnt_q;
    unpack_cnt_d = unpack_cnt_q;
    key_cnt_d    = key_cnt_q;
    iv_cnt_d     = iv_cnt_q;
    cbc_en_d     = cbc_en_q;
    in_wr_d      = in_wr_q;
    in_rd_d      = in_rd_q;
    out_wr_d     = out_wr_q;
    out_rd_d     = out_rd_q;
    in_cnt_d     = in_cnt_q + 4'(in_push) - 4'(in_pop);
    out_cnt_d    = out_cnt_q + 4'(out_push) - 4'(out_pop);

    if (din_acc) begin
      din_d      = din_shift;
      pack_cnt_d = (pack_cnt_q == LastWord) ? 3'd0 : pack_cnt_q + 3'd1;
    end
    if (dout_acc) unpack_cnt_d = (unpack_cnt_q == LastWord) ? 3'd0 : unpack_cnt_q + 3'd1;
    if (key_acc) begin
      key_d     = key_shift;
      key_cnt_d = (key_cnt_q == LastWord) ? 3'd0 : key_cnt_q + 3'd1;
    end
    if (iv_acc) begin
      iv_d     = iv_shift;
      iv_cnt_d = (iv_cnt_q == LastWord) ? 3'd0 : iv_cnt_q + 3'd1;
    end
    if (ctrl_acc) cbc_en_d = writedata[0];

    if (in_push)  in_wr_d  = (in_wr_q == InLast) ? '0 : in_wr_q + 1'b1;
    if (in_pop)   in_rd_d  = (in_rd_q == InLast) ? '0 : in_rd_q + 1'b1;
    if (out_push) out_wr_d = (out_wr_q == OutLast) ? '0 : out_wr_q + 1'b1;
    if (out_pop)  out_rd_d = (out_rd_q == OutLast) ? '0 : out_rd_q + 1'b1;

    if (flush) begin
      pack_cnt_d   = 3'd0;
      unpack_cnt_d = 3'd0;
      in_wr_d      = '0;
      in_rd_d      = '0;
      in_cnt_d     = 4'd0;
      out_wr_d     = '0;
      out_rd_d     = '0;
      out_cnt_d    = 4'd0;
    end
  end

  // Dispatch FSM; output space is reserved before leaving idle so the writeback cannot overflow.
  always_comb begin
    state_d  = state_q;
    text_d   = text_q;
    result_d = result_q;
    chain_d  = chain_q;
    if (iv_acc && iv_cnt_q == LastWord) chain_d = iv_shift;
    if (flush) chain_d = iv_q;
    unique case (state_q)
      StIdle: begin
        if (in_cnt_q != 4'd0 && out_cnt_q < OutDepth && !flush) begin
          text_d  = in_head ^ (cbc_en_q ? chain_q : 128'd0);
          state_d = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (core_done) begin
          result_d = core_result;
          state_d  = StWb;
        end
      end
      StWb: begin
        if (cbc_en_q) chain_d = result_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (in_push)  in_mem[in_wr_q]   <= din_shift;
    if (out_push) out_mem[out_wr_q] <= result_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      din_q        <= '0;
      key_q        <= '0;
      iv_q         <= '0;
      chain_q      <= '0;
      text_q       <= '0;
      result_q     <= '0;
      pack_cnt_q   <= '0;
      unpack_cnt_q <= '0;
      key_cnt_q    <= '0;
      iv_cnt_q     <= '0;
      cbc_en_q     <= 1'b0;
      in_wr_q      <= '0;
      in_rd_q      <= '0;
      out_wr_q     <= '0;
      out_rd_q     <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      key_q        <= key_d;
      iv_q         <= iv_d;
      chain_q      <= chain_d;
      text_q       <= text_d;
      result_q     <= result_d;
      pack_cnt_q   <= pack_cnt_d;
      unpack_cnt_q <= unpack_cnt_d;
      key_cnt_q    <= key_cnt_d;
      iv_cnt_q     <= iv_cnt_d;
      cbc_en_q     <= cbc_en_d;
      in_wr_q      <= in_wr_d;
      in_rd_q      <= in_rd_d;
      out_wr_q     <= out_wr_d;
      out_rd_q     <= out_rd_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

`ifdef AES_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_acc) irq_en_d = writedata[2];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q & out_avail;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_aes_stream_slave.sv
// Directed bench for aes_stream_slave (DATA_W=32, IN_DEPTH=2, OUT_DEPTH=1) with an xor stub engine
// and a transaction-level model of the block stream.
module tb_aes_stream_slave;
  localparam int unsigned DW = 32;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [3:0]    address = 4'h0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          waitrequest, core_start, core_done;
  logic [127:0]  core_text, core_key, core_result;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  aes_stream_slave #(.DATA_W(DW), .IN_DEPTH(2), .OUT_DEPTH(1)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .chipselect (chipselect),
    .address    (address),
    .read       (read),
    .readdata   (readdata),
    .write      (write),
    .writedata  (writedata),
    .waitrequest(waitrequest),
    .core_start (core_start),
    .core_text  (core_text),
    .core_key   (core_key),
    .core_done  (core_done),
    .core_result(core_result)
  );

  // Stub engine: result = text ^ key, done three cycles after start; deliberately never reset.
  logic [127:0] stub_text = '0;
  int           stub_cnt = 0;
  always @(posedge clock) begin
    if (core_start) begin
      stub_text <= core_text;
      stub_cnt  <= 3;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign core_done   = (stub_cnt == 1);
  assign core_result = stub_text ^ core_key;

  // Model state
  logic [127:0] m_key = '0, m_iv = '0, m_chain = '0, m_pack = '0;
  int           m_pack_n = 0, m_iv_n = 0;
  bit           m_cbc = 1'b0;
  logic [127:0] in_blocks[$];
  logic [31:0]  out_words[$];
  logic [127:0] seen_text[$];
  logic [127:0] exp_text, exp_res;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_iv = '0; m_chain = '0; m_pack = '0;
    m_pack_n = 0; m_iv_n = 0; m_cbc = 1'b0;
    in_blocks.delete(); out_words.delete();
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    case (a)
      4'h0: begin
        m_pack = {m_pack[95:0], d};
        m_pack_n++;
        if (m_pack_n == 4) begin in_blocks.push_back(m_pack); m_pack_n = 0; end
      end
      4'h1: m_key = {m_key[95:0], d};
      4'h2: begin
        m_iv = {m_iv[95:0], d};
        m_iv_n++;
        if (m_iv_n == 4) begin m_chain = m_iv; m_iv_n = 0; end
      end
      4'hC: begin
        m_cbc = d[0];
        if (d[1]) begin
          in_blocks.delete(); out_words.delete();
          m_pack_n = 0; m_chain = m_iv;
        end
      end
      default: ;
    endcase
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clock); #1;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    #1;
    while (waitrequest && n < 200) begin @(negedge clock); #2; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr %h still stalled after %0d cycles, required accept", a, n);
    end else begin
      @(posedge clock);
      model_write(a, d);
    end
    #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output int n);
    n = 0;
    @(negedge clock); #1;
    chipselect = 1'b1; read = 1'b1; address = a;
    #1;
    while (waitrequest && n < 200) begin @(negedge clock); #2; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL read_timeout: addr %h still stalled after %0d cycles, required data", a, n);
    end
    d = readdata;
    @(posedge clock); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic write_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) bus_write(4'h0, b[127 - 32*i -: 32]);
  endtask

  task automatic drain_words(input int nwords);
    logic [31:0] d;
    int          st;
    for (int i = 0; i < nwords; i++) bus_read(4'h4, d, st);
  endtask

  // Compare process: checks engine launches and every accepted DATA_OUT read against the model.
  always @(negedge clock) begin
    #4;
    if (resetn) begin
      chk("core_key", core_key, m_key);
      if (core_start) begin
        if (in_blocks.size() == 0) begin
          checks++; errors++;
          $display("FAIL core_start: got pulse, required none (no block queued)");
        end else begin
          exp_text = in_blocks.pop_front() ^ (m_cbc ? m_chain : 128'd0);
          chk("core_text", core_text, exp_text);
          seen_text.push_back(core_text);
          exp_res = exp_text ^ m_key;
          if (m_cbc) m_chain = exp_res;
          for (int i = 0; i < 4; i++) out_words.push_back(exp_res[127 - 32*i -: 32]);
        end
      end
      if (chipselect && read && address == 4'h4 && !waitrequest) begin
        if (out_words.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_out: got word %h, required no data available", readdata);
        end else begin
          chk("data_out", 128'(readdata), 128'(out_words.pop_front()));
        end
      end
    end
  end

  logic [31:0]  rd;
  int           st, n_hi, n;
  logic [127:0] key_vec = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] pt_vec  = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] ct_vec  = 128'h00102030405060708090a0b0c0d0e0f0;

  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_waitrequest", 128'(waitrequest), 128'd0);
    chk("rst_core_start", 128'(core_start), 128'd0);
    chk("rst_core_text", core_text, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    chk("rst_readdata", 128'(readdata), 128'd0);
    @(negedge clock); resetn = 1'b1;

    // ECB basic
    for (int i = 0; i < 4; i++) bus_write(4'h1, key_vec[127 - 32*i -: 32]);
    write_block(pt_vec);
    chk("ecb_start_lat0", 128'(core_start), 128'd0);
    @(posedge clock); #1;
    chk("ecb_start_lat1", 128'(core_start), 128'd1);
    chk("ecb_core_text", core_text, pt_vec);
    for (int i = 0; i < 4; i++) begin
      bus_read(4'h4, rd, st);
      chk("ecb_word", 128'(rd), 128'(ct_vec[127 - 32*i -: 32]));
      if (i == 0) chk("ecb_empty_stall", 128'(st > 0), 128'd1);
    end
    bus_read(4'h8, rd, st);
    chk("ecb_status_after", 128'(rd), 128'd0);

    // Backpressure: one result parked, two blocks queued, fourth block's last word stalls
    for (int b = 0; b < 3; b++)
      write_block({32'h1000_0000 * b, 32'h1111_1111, 32'h2222_2222, 32'h3000_0000 + b});
    bus_write(4'h0, 32'haaaa_0003);
    bus_write(4'h0, 32'hbbbb_0003);
    bus_write(4'h0, 32'hcccc_0003);
    repeat (8) @(posedge clock);
    bus_read(4'h8, rd, st);
    chk("bp_status", 128'(rd), 128'h123);
    @(negedge clock); #1;
    chipselect = 1'b1; write = 1'b1; address = 4'h0; writedata = 32'hdddd_0003;
    n_hi = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clock); #2; if (waitrequest) n_hi++; end
    chipselect = 1'b0; write = 1'b0;
    chk("bp_last_word_stall", 128'(n_hi), 128'd10);
    drain_words(4);
    bus_write(4'h0, 32'hdddd_0003);
    drain_words(12);
    chk("bp_all_drained", 128'(out_words.size() + in_blocks.size()), 128'd0);

    // CBC chaining
    for (int i = 0; i < 4; i++) bus_write(4'h2, 32'hffff_ffff);
    bus_write(4'hC, 32'h1);
    seen_text.delete();
    write_block(128'd0);
    write_block(128'd0);
    drain_words(8);
    if (seen_text.size() < 2) begin
      checks++; errors++;
      $display("FAIL cbc_launches: got %0d, required 2", seen_text.size());
    end else begin
      chk("cbc_text1", seen_text[0], {128{1'b1}});
      chk("cbc_text2", seen_text[1], 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
    end
    bus_write(4'hC, 32'h3);
    seen_text.delete();
    write_block(128'd0);
    drain_words(4);
    for (int i = 0; i < 4; i++) bus_write(4'h2, (i == 3) ? 32'h1 : 32'h0);
    write_block(128'd0);
    drain_words(4);
    if (seen_text.size() < 2) begin
      checks++; errors++;
      $display("FAIL flush_launches: got %0d, required 2", seen_text.size());
    end else begin
      chk("flush_chain_iv", seen_text[0], {128{1'b1}});
      chk("reload_chain_iv", seen_text[1], 128'd1);
    end
    bus_write(4'hC, 32'h0);

    // Reset while the engine is busy
    write_block(128'h5);
    n = 0;
    while (!core_start && n < 50) begin @(negedge clock); #2; n++; end
    chk("rst_test_launch", 128'(core_start), 128'd1);
    @(negedge clock); #1;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("midrst_core_start", 128'(core_start), 128'd0);
    chk("midrst_core_text", core_text, 128'd0);
    chk("midrst_core_key", core_key, 128'd0);
    chk("midrst_waitrequest", 128'(waitrequest), 128'd0);
    chk("midrst_readdata", 128'(readdata), 128'd0);
    @(negedge clock); resetn = 1'b1;
    repeat (8) @(posedge clock);
    bus_read(4'h8, rd, st);
    chk("late_done_ignored", 128'(rd), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
